// File: rtl/lock_pkg.sv
// Shared types and display constants for the code-entry lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_e;

  // Segment patterns, bit0 = segment a, active-high.
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b0000110;
  localparam logic [6:0] SEG_TWO   = 7'b1011011;
  localparam logic [6:0] SEG_THREE = 7'b1001111;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;

  // Moore status word {unlock, segments} for a given state and digit index.
  function automatic logic [7:0] status_word(input lock_state_e st, input logic [1:0] idx);
    logic [6:0] seg;
    seg = SEG_DASH;
    case (st)
      IDLE:    seg = SEG_DASH;
      ENTRY: begin
        case (idx)
          2'd1:    seg = SEG_ONE;
          2'd2:    seg = SEG_TWO;
          2'd3:    seg = SEG_THREE;
          default: seg = SEG_DASH;
        endcase
      end
      OPEN:    seg = SEG_U;
      FAIL:    seg = SEG_E;
      LOCKOUT: seg = SEG_L;
      default: seg = SEG_DASH;
    endcase
    return {(st == OPEN), seg};
  endfunction

endpackage

// File: rtl/lock_input_sync.sv
// Two-flop synchroniser for {clear, enter, digit} plus the enter edge detector.
module lock_input_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] async_in,   // {clear, enter, digit[3:0]}
  output logic [3:0] digit,
  output logic       clear,
  output logic       ent
);

  logic [5:0] s1_r;
  logic [5:0] s2_r;
  logic       s3_r;

  // Synchroniser chain; s3 remembers the previous synced enter level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 6'd0;
      s2_r <= 6'd0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r[4];
    end
  end

  assign digit = s2_r[3:0];
  assign clear = s2_r[5];
  assign ent   = s2_r[4] & ~s3_r;

endmodule

// File: rtl/lock_sequencer.sv
// Four-digit code-entry sequencer with fail indication and timed lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1A7C,
  parameter int          MAX_TRIES      = 3,
  parameter int          FAIL_CYCLES    = 8,
  parameter int          LOCKOUT_CYCLES = 64
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic               clk_s;
  logic               arst_n_s;
  logic               rst_n_s;
  logic [1:0]         rst_sync_r;
  logic [3:0]         digit_s;
  logic               clear_s;
  logic               ent_s;
  logic               mism_next_s;

  lock_state_e        state_r, state_n;
  logic [1:0]         idx_r, idx_n;
  logic               mism_r, mism_n;
  logic [TRIES_W-1:0] tries_r, tries_n;
  logic [TMR_W-1:0]   tmr_r, tmr_n;
  logic [7:0]         out_r;

  assign clk_s    = io_in[0];
  assign arst_n_s = io_in[1];

  // Expected digit for a given entry position, first digit in the top nibble.
  function automatic logic [3:0] code_nibble(input logic [1:0] pos);
    case (pos)
      2'd0:    return CODE[15:12];
      2'd1:    return CODE[11:8];
      2'd2:    return CODE[7:4];
      default: return CODE[3:0];
    endcase
  endfunction

  // Reset asserts immediately and releases two clocks later.
  always_ff @(posedge clk_s or negedge arst_n_s) begin
    if (!arst_n_s) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  lock_input_sync u_sync (
    .clk      (clk_s),
    .rst_n    (rst_n_s),
    .async_in (io_in[7:2]),
    .digit    (digit_s),
    .clear    (clear_s),
    .ent      (ent_s)
  );

  assign mism_next_s = mism_r | (digit_s != code_nibble(idx_r));

  // State and counter registers; the output word is registered from the next state.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      mism_r  <= 1'b0;
      tries_r <= '0;
      tmr_r   <= '0;
      out_r   <= 8'h40;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      mism_r  <= mism_n;
      tries_r <= tries_n;
      tmr_r   <= tmr_n;
      out_r   <= status_word(state_n, idx_n);
    end
  end

  // Next-state logic: clear wins over enter everywhere except lockout.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    mism_n  = mism_r;
    tries_n = tries_r;
    tmr_n   = tmr_r;
    if (clear_s && (state_r != LOCKOUT)) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      mism_n  = 1'b0;
      tmr_n   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ent_s) begin
            state_n = ENTRY;
            idx_n   = 2'd1;
            mism_n  = (digit_s != code_nibble(2'd0));
          end else begin
            state_n = IDLE;
          end
        end
        ENTRY: begin
          if (ent_s) begin
            idx_n  = idx_r + 2'd1;
            mism_n = mism_next_s;
            if (idx_r == 2'd3) begin
              mism_n = 1'b0;
              if (!mism_next_s) begin
                state_n = OPEN;
                tries_n = '0;
              end else begin
                tries_n = (tries_r == TRIES_W'(MAX_TRIES)) ? tries_r : tries_r + TRIES_W'(1);
                if (tries_r == TRIES_W'(MAX_TRIES - 1)) begin
                  state_n = LOCKOUT;
                  tmr_n   = TMR_W'(LOCKOUT_CYCLES - 1);
                end else begin
                  state_n = FAIL;
                  tmr_n   = TMR_W'(FAIL_CYCLES - 1);
                end
              end
            end else begin
              state_n = ENTRY;
            end
          end else begin
            state_n = ENTRY;
          end
        end
        OPEN: begin
          if (ent_s) begin
            state_n = IDLE;
          end else begin
            state_n = OPEN;
          end
        end
        FAIL: begin
          if (tmr_r == '0) begin
            state_n = IDLE;
          end else begin
            tmr_n = tmr_r - TMR_W'(1);
          end
        end
        LOCKOUT: begin
          if (tmr_r == '0) begin
            state_n = IDLE;
            tries_n = '0;
          end else begin
            tmr_n = tmr_r - TMR_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = 2'd0;
          mism_n  = 1'b0;
          tmr_n   = '0;
        end
      endcase
    end
  end

  assign io_out = out_r;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a press-level model predicts every
// change of io_out; a monitor pops and compares each change it observes.
module tb_lock_sequencer;

  localparam logic [15:0] CODE_V = 16'h1A7C;
  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_BLOCK = 3;

  typedef struct {
    logic [7:0] val;
    int         dur;   // expected cycles this value persists (0 = unchecked)
    int         at;    // expected edge number of the change (0 = unchecked)
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       enter = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  exp_t       exp_q[$];

  // Reference model state: what the user has done, not how the RTL stores it.
  int         mode = M_IDLE;
  logic [3:0] entered[$];
  int         tries = 0;

  assign io_in = {clr, enter, sw, rst_n, clk};

  lock_sequencer dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [7:0] v, input int d, input int a);
    exp_t e;
    e.val = v;
    e.dur = d;
    e.at  = a;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] code_digit(input int pos);
    logic [15:0] cv;
    cv = CODE_V;
    return cv[4*(3-pos) +: 4];
  endfunction

  function automatic logic [7:0] entry_pat(input int n);
    case (n)
      1:       return 8'h06;
      2:       return 8'h5B;
      default: return 8'h4F;
    endcase
  endfunction

  // Monitor: every observed change of io_out consumes one expectation.
  logic [7:0] prev = 8'h40;
  int         pend_dur = 0;
  int         t_chg = 0;
  always @(posedge clk) begin
    #1;
    if (mon_en && (io_out !== prev)) begin
      if (pend_dur > 0) begin
        total++;
        if (cyc - t_chg != pend_dur) begin
          bad++;
          $display("FAIL duration of %h: got %0d cycles expected %0d", prev, cyc - t_chg, pend_dur);
        end
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected change: got %h expected no change", io_out);
        pend_dur = 0;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("display", io_out, e.val);
        if (e.at != 0) begin
          total++;
          if (cyc != e.at) begin
            bad++;
            $display("FAIL latency of %h: got edge %0d expected edge %0d", e.val, cyc, e.at);
          end
        end
        pend_dur = e.dur;
      end
      t_chg = cyc;
      prev  = io_out;
    end
  end

  task automatic do_press(input logic [3:0] d, input int hold, input int gap, input bit settle);
    int  c;
    int  w;
    bit  ok;
    @(negedge clk);
    c = cyc;
    sw = d;
    enter = 1'b1;
    w = 0;
    if (mode == M_IDLE || mode == M_ENTRY) begin
      entered.push_back(d);
      if (entered.size() < 4) begin
        push_exp(entry_pat(entered.size()), 0, c + 3);
        mode = M_ENTRY;
      end else begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (entered[i] != code_digit(i)) ok = 1'b0;
        entered.delete();
        if (ok) begin
          push_exp(8'hBE, 0, c + 3);
          tries = 0;
          mode = M_OPEN;
        end else begin
          tries++;
          mode = M_BLOCK;
          if (tries == 3) begin
            push_exp(8'h38, 64, c + 3);
            push_exp(8'h40, 0, 0);
            tries = 0;
            w = 66;
          end else begin
            push_exp(8'h79, 8, c + 3);
            push_exp(8'h40, 0, 0);
            w = 10;
          end
        end
      end
    end else if (mode == M_OPEN) begin
      push_exp(8'h40, 0, c + 3);
      mode = M_IDLE;
    end
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (gap) @(negedge clk);
    if (settle && w > 0) begin
      repeat (w) @(negedge clk);
      mode = M_IDLE;
    end
  endtask

  task automatic do_clear(input int hold, input int gap);
    int c;
    @(negedge clk);
    c = cyc;
    clr = 1'b1;
    if (mode == M_ENTRY || mode == M_OPEN) begin
      push_exp(8'h40, 0, c + 3);
      entered.delete();
      mode = M_IDLE;
    end
    repeat (hold) @(negedge clk);
    clr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] cv;
    cv = code;
    for (int i = 0; i < 4; i++) do_press(cv[4*(3-i) +: 4], 2, 3, 1'b1);
  endtask

  initial begin
    int c;
    // Power-up reset.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_assert", io_out, 8'h40);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_release", io_out, 8'h40);
    prev = 8'h40;
    mon_en = 1'b1;

    // Correct code, then an enter leaves OPEN.
    enter_code(16'h1A7C);
    do_press(4'h0, 2, 3, 1'b1);

    // Single wrong digit, then a correct code clears the try count.
    enter_code(16'h1A7D);
    enter_code(16'h1A7C);
    do_press(4'h5, 2, 3, 1'b1);

    // Three wrong entries: lockout ignores enter and clear.
    enter_code(16'h2A7C);
    enter_code(16'h1B7C);
    for (int i = 0; i < 3; i++) do_press(code_digit(i), 2, 3, 1'b1);
    do_press(4'hF, 2, 3, 1'b0);
    do_press(4'h1, 2, 3, 1'b0);
    do_clear(2, 3);
    repeat (60) @(negedge clk);
    mode = M_IDLE;
    enter_code(16'h1A7C);
    do_clear(2, 3);

    // Clear and an enter edge in the same cycle at idx 2.
    do_press(4'h1, 2, 3, 1'b1);
    do_press(4'hA, 2, 3, 1'b1);
    @(negedge clk);
    c = cyc;
    sw = 4'h7;
    enter = 1'b1;
    clr = 1'b1;
    push_exp(8'h40, 0, c + 3);
    entered.delete();
    mode = M_IDLE;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    do_press(4'h1, 2, 3, 1'b1);
    do_clear(2, 3);

    // Held enter consumes exactly one digit.
    do_press(4'h1, 20, 3, 1'b1);
    do_clear(2, 3);

    // Reset mid-entry takes effect without a clock edge.
    do_press(4'h1, 2, 3, 1'b1);
    do_press(4'hA, 2, 3, 1'b1);
    @(negedge clk);
    push_exp(8'h40, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_entry", io_out, 8'h40);
    entered.delete();
    mode = M_IDLE;
    tries = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_mid_release", io_out, 8'h40);
    repeat (5) @(negedge clk);

    // Randomised presses and clears.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      if (r < 80) begin
        if ((mode == M_IDLE || mode == M_ENTRY) && ($urandom_range(0, 9) < 8))
          d = code_digit(entered.size());
        else
          d = 4'($urandom_range(0, 15));
        do_press(d, $urandom_range(1, 4), $urandom_range(2, 5), 1'b1);
      end else begin
        do_clear($urandom_range(1, 3), $urandom_range(2, 4));
      end
    end

    // Drain: every predicted change must have been observed.
    repeat (80) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending changes expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
